// File: rtl/aib_drv_pkg.sv
// Shared types for the AIB pad-driver control block: config FSM states,
// driver leg encoding, and the 4-bit dead/settle counter type.
package aib_drv_pkg;

  localparam int unsigned CNT_W = 4;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    QUIESCE = 2'd1,
    APPLY   = 2'd2,
    SETTLE  = 2'd3
  } cfg_state_e;

  typedef enum logic [1:0] {
    LEG_OFF = 2'd0,
    LEG_PU  = 2'd1,
    LEG_PD  = 2'd2
  } leg_e;

  // Leg the channel wants given its enable, data and quiesce state
  function automatic leg_e target_leg(input logic quiesce, input logic oe, input logic data);
    if (quiesce || !oe) return LEG_OFF;
    return data ? LEG_PU : LEG_PD;
  endfunction

endpackage

// File: rtl/aib_driver_ctrl_mc_if.sv
// Configuration request bus: valid/ready handshake carrying channel mask,
// strength codes and weak-pull enables.
interface aib_driver_ctrl_mc_if #(
  parameter int unsigned NCH   = 4,
  parameter int unsigned DRV_W = 3
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [NCH-1:0]   cfg_ch_mask;
  logic [DRV_W-1:0] cfg_pcode;
  logic [DRV_W-1:0] cfg_ncode;
  logic             cfg_pu_en;
  logic             cfg_pd_en;

  modport master (
    output cfg_valid, cfg_ch_mask, cfg_pcode, cfg_ncode, cfg_pu_en, cfg_pd_en,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_ch_mask, cfg_pcode, cfg_ncode, cfg_pu_en, cfg_pd_en,
    output cfg_ready
  );
endinterface

// File: rtl/aib_drv_bbm_chan.sv
// One pad channel: target-leg selection, break-before-make dead counter and
// registered PU/PD leg drives. Also exports the last driven value and
// whether the channel is undriven next cycle, for the optional bus keeper.
module aib_drv_bbm_chan
  import aib_drv_pkg::*;
#(
  parameter int unsigned DEAD_CYC = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic quiesce,
  input  logic tx_data,
  input  logic tx_oe,
  output logic pdrv_n,
  output logic ndrv,
  output logic idle_safe_c,
  output logic keep_c,
  output logic last_c
);

  leg_e leg_q, leg_d, tgt;
  cnt_t cnt_q, cnt_d;
  logic last_q, last_d;
  logic pdrv_n_q, pdrv_n_d;
  logic ndrv_q, ndrv_d;

  // Leg sequencing: drop the active leg, wait out the dead time, then engage the latest target
  always_comb begin
    leg_d  = leg_q;
    cnt_d  = cnt_q;
    last_d = last_q;
    tgt    = target_leg(quiesce, tx_oe, tx_data);
    if (leg_q != LEG_OFF) begin
      if (tgt != leg_q) begin
        leg_d = LEG_OFF;
        cnt_d = cnt_t'(DEAD_CYC);
      end
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - cnt_t'(1);
    end else if (tgt != LEG_OFF) begin
      leg_d  = tgt;
      last_d = (tgt == LEG_PU);
    end
    pdrv_n_d = (leg_d != LEG_PU);
    ndrv_d   = (leg_d == LEG_PD);
  end

  // Leg, dead counter and pad drive registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      leg_q    <= LEG_OFF;
      cnt_q    <= '0;
      last_q   <= 1'b0;
      pdrv_n_q <= 1'b1;
      ndrv_q   <= 1'b0;
    end else begin
      leg_q    <= leg_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      pdrv_n_q <= pdrv_n_d;
      ndrv_q   <= ndrv_d;
    end
  end

  assign pdrv_n      = pdrv_n_q;
  assign ndrv        = ndrv_q;
  assign idle_safe_c = (leg_q == LEG_OFF) && (cnt_q == '0);
  assign keep_c      = (leg_d == LEG_OFF) && !tx_oe && !quiesce;
  assign last_c      = last_d;

endmodule

// File: rtl/aib_driver_ctrl_mc.sv
// Multi-channel AIB pad-driver control front-end. Per-channel break-before-make
// leg control plus a config FSM that quiesces, updates and settles the masked
// channels' strength codes and weak pulls.
// Optional feature: define AIB_DRV_KEEPER_EN to enable the weak-pull bus keeper
// on undriven channels that have no configured pull.
module aib_driver_ctrl_mc
  import aib_drv_pkg::*;
#(
  parameter int unsigned NCH      = 4,
  parameter int unsigned DRV_W    = 3,
  parameter int unsigned DEAD_CYC = 2,
  parameter int unsigned SETL_CYC = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH-1:0]       tx_data,
  input  logic [NCH-1:0]       tx_oe,
  aib_driver_ctrl_mc_if.slave  cfg,
  output logic [NCH-1:0]       pdrv_n,
  output logic [NCH-1:0]       ndrv,
  output logic [NCH*DRV_W-1:0] c_pdrv,
  output logic [NCH*DRV_W-1:0] c_ndrv,
  output logic [NCH-1:0]       c_pu_n,
  output logic [NCH-1:0]       c_pd,
  output logic                 busy
);

`ifdef AIB_DRV_KEEPER_EN
  localparam bit KEEPER_EN = 1'b1;
`else
  localparam bit KEEPER_EN = 1'b0;
`endif

  cfg_state_e           state_q, state_d;
  cnt_t                 settle_q, settle_d;
  logic [NCH-1:0]       mask_q, mask_d;
  logic [DRV_W-1:0]     pcode_cap_q, pcode_cap_d;
  logic [DRV_W-1:0]     ncode_cap_q, ncode_cap_d;
  logic                 pu_cap_q, pu_cap_d;
  logic                 pd_cap_q, pd_cap_d;
  logic [NCH*DRV_W-1:0] c_pdrv_q, c_pdrv_d;
  logic [NCH*DRV_W-1:0] c_ndrv_q, c_ndrv_d;
  logic [NCH-1:0]       pu_cfg_q, pu_cfg_d;
  logic [NCH-1:0]       pd_cfg_q, pd_cfg_d;
  logic [NCH-1:0]       c_pu_n_q, c_pu_n_d;
  logic [NCH-1:0]       c_pd_q, c_pd_d;
  logic                 busy_q, busy_d;
  logic                 cfg_ready_q, cfg_ready_d;

  logic [NCH-1:0]       quiesce_c;
  logic [NCH-1:0]       idle_safe_c;
  logic [NCH-1:0]       keep_c;
  logic [NCH-1:0]       last_c;

  assign quiesce_c = (state_q != IDLE) ? mask_q : '0;

  // Per-channel leg control
  for (genvar g = 0; g < NCH; g++) begin : g_ch
    aib_drv_bbm_chan #(.DEAD_CYC(DEAD_CYC)) u_chan (
      .clk         (clk),
      .rst_n       (rst_n),
      .quiesce     (quiesce_c[g]),
      .tx_data     (tx_data[g]),
      .tx_oe       (tx_oe[g]),
      .pdrv_n      (pdrv_n[g]),
      .ndrv        (ndrv[g]),
      .idle_safe_c (idle_safe_c[g]),
      .keep_c      (keep_c[g]),
      .last_c      (last_c[g])
    );
  end

  // Config FSM: capture, quiesce masked legs, apply codes/pulls, settle
  always_comb begin
    state_d     = state_q;
    settle_d    = settle_q;
    mask_d      = mask_q;
    pcode_cap_d = pcode_cap_q;
    ncode_cap_d = ncode_cap_q;
    pu_cap_d    = pu_cap_q;
    pd_cap_d    = pd_cap_q;
    c_pdrv_d    = c_pdrv_q;
    c_ndrv_d    = c_ndrv_q;
    pu_cfg_d    = pu_cfg_q;
    pd_cfg_d    = pd_cfg_q;
    case (state_q)
      IDLE: begin
        if (cfg.cfg_valid && cfg_ready_q) begin
          mask_d      = cfg.cfg_ch_mask;
          pcode_cap_d = cfg.cfg_pcode;
          ncode_cap_d = cfg.cfg_ncode;
          pu_cap_d    = cfg.cfg_pu_en;
          pd_cap_d    = cfg.cfg_pd_en;
          state_d     = QUIESCE;
        end
      end
      QUIESCE: begin
        if (&(idle_safe_c | ~mask_q)) state_d = APPLY;
      end
      APPLY: begin
        for (int i = 0; i < NCH; i++) begin
          if (mask_q[i]) begin
            c_pdrv_d[i*DRV_W +: DRV_W] = pcode_cap_q;
            c_ndrv_d[i*DRV_W +: DRV_W] = ncode_cap_q;
            pd_cfg_d[i]                = pd_cap_q;
            pu_cfg_d[i]                = pu_cap_q && !pd_cap_q;
          end
        end
        settle_d = cnt_t'(SETL_CYC);
        state_d  = SETTLE;
      end
      SETTLE: begin
        settle_d = settle_q - cnt_t'(1);
        if (settle_q <= cnt_t'(1)) begin
          settle_d = '0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d      = (state_d != IDLE);
    cfg_ready_d = (state_d == IDLE);
  end

  // Weak-pull outputs: configured pulls, plus the keeper on undriven unpulled channels
  always_comb begin
    c_pu_n_d = '1;
    c_pd_d   = '0;
    for (int i = 0; i < NCH; i++) begin
      c_pu_n_d[i] = !(pu_cfg_d[i] ||
                      (KEEPER_EN && keep_c[i] && !pu_cfg_d[i] && !pd_cfg_d[i] && last_c[i]));
      c_pd_d[i]   = pd_cfg_d[i] ||
                    (KEEPER_EN && keep_c[i] && !pu_cfg_d[i] && !pd_cfg_d[i] && !last_c[i]);
    end
  end

  // FSM, captured request and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      settle_q    <= '0;
      mask_q      <= '0;
      pcode_cap_q <= '0;
      ncode_cap_q <= '0;
      pu_cap_q    <= 1'b0;
      pd_cap_q    <= 1'b0;
      c_pdrv_q    <= '0;
      c_ndrv_q    <= '0;
      pu_cfg_q    <= '0;
      pd_cfg_q    <= '0;
      c_pu_n_q    <= '1;
      c_pd_q      <= '0;
      busy_q      <= 1'b0;
      cfg_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      settle_q    <= settle_d;
      mask_q      <= mask_d;
      pcode_cap_q <= pcode_cap_d;
      ncode_cap_q <= ncode_cap_d;
      pu_cap_q    <= pu_cap_d;
      pd_cap_q    <= pd_cap_d;
      c_pdrv_q    <= c_pdrv_d;
      c_ndrv_q    <= c_ndrv_d;
      pu_cfg_q    <= pu_cfg_d;
      pd_cfg_q    <= pd_cfg_d;
      c_pu_n_q    <= c_pu_n_d;
      c_pd_q      <= c_pd_d;
      busy_q      <= busy_d;
      cfg_ready_q <= cfg_ready_d;
    end
  end

  assign c_pdrv        = c_pdrv_q;
  assign c_ndrv        = c_ndrv_q;
  assign c_pu_n        = c_pu_n_q;
  assign c_pd          = c_pd_q;
  assign busy          = busy_q;
  assign cfg.cfg_ready = cfg_ready_q;

endmodule

// File: tb/tb_aib_driver_ctrl_mc.sv
// Bench for aib_driver_ctrl_mc: timestamp-based reference model feeding a
// scoreboard queue, a monitor comparing every cycle, plus directed checks.
module tb_aib_driver_ctrl_mc;

  localparam int NCH   = 4;
  localparam int DRV_W = 3;
  localparam int DEAD  = 2;
  localparam int SETL  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NCH-1:0]       tx_data, tx_oe;
  logic [NCH-1:0]       pdrv_n, ndrv, c_pu_n, c_pd;
  logic [NCH*DRV_W-1:0] c_pdrv, c_ndrv;
  logic                 busy;

  aib_driver_ctrl_mc_if #(.NCH(NCH), .DRV_W(DRV_W)) cfg_if ();

  aib_driver_ctrl_mc #(.NCH(NCH), .DRV_W(DRV_W), .DEAD_CYC(DEAD), .SETL_CYC(SETL)) dut (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_oe(tx_oe), .cfg(cfg_if.slave),
    .pdrv_n(pdrv_n), .ndrv(ndrv), .c_pdrv(c_pdrv), .c_ndrv(c_ndrv),
    .c_pu_n(c_pu_n), .c_pd(c_pd), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NCH-1:0]       pdrv_n, ndrv;
    logic [NCH*DRV_W-1:0] c_pdrv, c_ndrv;
    logic [NCH-1:0]       c_pu_n, c_pd;
    logic                 busy, rdy;
  } exp_t;

  exp_t exp_q[$];
  int errors = 0;
  int checks = 0;

  // Stimulus state (what the master currently drives)
  logic [NCH-1:0]   cur_data, cur_oe, req_mask;
  logic             req_v, req_pu, req_pd;
  logic [DRV_W-1:0] req_pc, req_nc;

  // Reference model: legs as 0=off 1=pu 2=pd, toff = edge index the leg last went off
  int               m_e, m_acc, m_apply, m_rel;
  int               m_leg[NCH];
  int               m_toff[NCH];
  bit               m_last[NCH];
  bit               m_pu[NCH], m_pd[NCH];
  logic [DRV_W-1:0] m_pc[NCH], m_nc[NCH];
  bit               m_upd, m_rdy;
  logic [NCH-1:0]   m_mask;
  logic [DRV_W-1:0] m_cpc, m_cnc;
  bit               m_cpu, m_cpd;

  function automatic void m_reset();
    m_e = 0; m_acc = -1; m_apply = -1; m_rel = -1; m_upd = 0; m_rdy = 0; m_mask = '0;
    for (int i = 0; i < NCH; i++) begin
      m_leg[i] = 0; m_toff[i] = -100; m_last[i] = 0;
      m_pu[i] = 0; m_pd[i] = 0; m_pc[i] = '0; m_nc[i] = '0;
    end
  endfunction

  function automatic void chk(string name, logic [31:0] got, logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s @%0t: got %h, required %h", name, $time, got, req);
    end
  endfunction

  // Drive current stimulus, advance the model by one clock edge, queue its outputs
  task automatic step();
    int ebar;
    bit all_safe;
    logic [NCH-1:0] q;
    int tgt;
    exp_t ex;
    bit keep;
    tx_data = cur_data; tx_oe = cur_oe;
    cfg_if.cfg_valid = req_v; cfg_if.cfg_ch_mask = req_mask;
    cfg_if.cfg_pcode = req_pc; cfg_if.cfg_ncode = req_nc;
    cfg_if.cfg_pu_en = req_pu; cfg_if.cfg_pd_en = req_pd;

    ebar = m_e + 1;
    q = m_upd ? m_mask : '0;
    all_safe = 1;
    for (int i = 0; i < NCH; i++)
      if (m_mask[i] && !(m_leg[i] == 0 && ebar - m_toff[i] >= DEAD + 1)) all_safe = 0;
    for (int i = 0; i < NCH; i++) begin
      tgt = (q[i] || !cur_oe[i]) ? 0 : (cur_data[i] ? 1 : 2);
      if (m_leg[i] != 0 && tgt != m_leg[i]) begin
        m_leg[i] = 0; m_toff[i] = ebar;
      end else if (m_leg[i] == 0 && tgt != 0 && ebar - m_toff[i] >= DEAD + 1) begin
        m_leg[i] = tgt; m_last[i] = (tgt == 1);
      end
    end
    if (m_upd) begin
      if (m_apply < 0) begin
        if (all_safe) begin m_apply = ebar + 1; m_rel = m_apply + SETL; end
      end else if (ebar == m_apply) begin
        for (int i = 0; i < NCH; i++)
          if (m_mask[i]) begin
            m_pc[i] = m_cpc; m_nc[i] = m_cnc; m_pd[i] = m_cpd; m_pu[i] = m_cpu && !m_cpd;
          end
      end
      if (ebar == m_rel) m_upd = 0;
    end else if (req_v && m_rdy) begin
      m_upd = 1; m_acc = ebar; m_apply = -1; m_rel = -1;
      m_mask = req_mask; m_cpc = req_pc; m_cnc = req_nc; m_cpu = req_pu; m_cpd = req_pd;
      req_v = 1'b0;
    end
    m_rdy = !m_upd;
    m_e = ebar;

    for (int i = 0; i < NCH; i++) begin
`ifdef AIB_DRV_KEEPER_EN
      keep = (m_leg[i] == 0) && !cur_oe[i] && !q[i] && !m_pu[i] && !m_pd[i];
`else
      keep = 0;
`endif
      ex.pdrv_n[i] = (m_leg[i] != 1);
      ex.ndrv[i]   = (m_leg[i] == 2);
      ex.c_pdrv[i*DRV_W +: DRV_W] = m_pc[i];
      ex.c_ndrv[i*DRV_W +: DRV_W] = m_nc[i];
      ex.c_pu_n[i] = !(m_pu[i] || (keep && m_last[i]));
      ex.c_pd[i]   = m_pd[i] || (keep && !m_last[i]);
    end
    ex.busy = m_upd;
    ex.rdy  = m_rdy;
    exp_q.push_back(ex);
    @(negedge clk);
  endtask

  task automatic chk_reset_vals(string tag);
    chk({tag, "_pdrv_n"}, 32'(pdrv_n), 32'hF);
    chk({tag, "_ndrv"},   32'(ndrv), 32'h0);
    chk({tag, "_c_pdrv"}, 32'(c_pdrv), 32'h0);
    chk({tag, "_c_ndrv"}, 32'(c_ndrv), 32'h0);
    chk({tag, "_c_pu_n"}, 32'(c_pu_n), 32'hF);
    chk({tag, "_c_pd"},   32'(c_pd), 32'h0);
    chk({tag, "_ready"},  32'(cfg_if.cfg_ready), 32'h0);
    chk({tag, "_busy"},   32'(busy), 32'h0);
  endtask

  // Monitor: compare DUT against the queued model outputs after every edge
  initial begin
    exp_t ex, got;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && exp_q.size() > 0) begin
        ex = exp_q.pop_front();
        got = '{pdrv_n, ndrv, c_pdrv, c_ndrv, c_pu_n, c_pd, busy, cfg_if.cfg_ready};
        checks++;
        if (got !== ex) begin
          errors++;
          $display("FAIL outputs @%0t: got pdrv_n=%b ndrv=%b c_pdrv=%h c_ndrv=%h c_pu_n=%b c_pd=%b busy=%b rdy=%b; required pdrv_n=%b ndrv=%b c_pdrv=%h c_ndrv=%h c_pu_n=%b c_pd=%b busy=%b rdy=%b",
                   $time, got.pdrv_n, got.ndrv, got.c_pdrv, got.c_ndrv, got.c_pu_n, got.c_pd, got.busy, got.rdy,
                   ex.pdrv_n, ex.ndrv, ex.c_pdrv, ex.c_ndrv, ex.c_pu_n, ex.c_pd, ex.busy, ex.rdy);
        end
        checks++;
        if ((~pdrv_n & ndrv) != '0) begin
          errors++;
          $display("FAIL overlap @%0t: got pu_on&pd_on=%b, required 0000", $time, ~pdrv_n & ndrv);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, required finish before 1000000");
    $fatal(1);
  end

  initial begin
    int k;
    cur_data = '0; cur_oe = '0; req_v = 0; req_mask = '0; req_pc = '0; req_nc = '0;
    req_pu = 0; req_pd = 0;
    tx_data = '0; tx_oe = '0;
    cfg_if.cfg_valid = 0; cfg_if.cfg_ch_mask = '0; cfg_if.cfg_pcode = '0;
    cfg_if.cfg_ncode = '0; cfg_if.cfg_pu_en = 0; cfg_if.cfg_pd_en = 0;
    m_reset();
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1'b1;
    m_reset();

    // Ready one cycle after release; ch0 PU with 1-cycle latency
    cur_oe = 4'b0001; cur_data = 4'b0001;
    step();
    chk("ready_after_reset", 32'(cfg_if.cfg_ready), 32'h1);
    chk("ch0_pu_latency", 32'(pdrv_n), 32'hE);
    step();

    // PU -> PD break-before-make
    cur_data = 4'b0000;
    step();
    chk("bbm_pu_off", 32'(pdrv_n[0]), 32'h1);
    step(); step();
    chk("bbm_pd_not_yet", 32'(ndrv[0]), 32'h0);
    step();
    chk("bbm_pd_on", 32'(ndrv[0]), 32'h1);

    // Fast toggling, then settle to final data
    for (int i = 0; i < 100; i++) begin
      cur_data[0] = ~cur_data[0];
      step();
    end
    repeat (DEAD + 3) step();
    chk("toggle_final_pd", 32'(ndrv[0]), 32'h1);
    chk("toggle_final_pu_off", 32'(pdrv_n[0]), 32'h1);

    // Config update on ch1 while ch0 keeps driving
    cur_oe = 4'b0011; cur_data = 4'b0011;
    repeat (5) step();
    req_v = 1; req_mask = 4'b0010; req_pc = 3'd5; req_nc = 3'd3; req_pu = 1; req_pd = 0;
    k = 0;
    while ((req_v || m_upd) && k < 60) begin
      step();
      chk("ch0_undisturbed", 32'(pdrv_n[0]), 32'h0);
      k++;
    end
    chk("cfg_done_bound", 32'(k < 60), 32'h1);
    step(); step();
    chk("cfg_pcode", 32'(c_pdrv), 32'h028);
    chk("cfg_ncode", 32'(c_ndrv), 32'h018);
    chk("cfg_pull_up", 32'(c_pu_n), 32'hD);
    chk("ch1_resumed", 32'(pdrv_n), 32'hC);

    // Reset during SETTLE
    req_v = 1; req_mask = 4'b0100; req_pc = 3'd7; req_nc = 3'd1; req_pu = 0; req_pd = 1;
    k = 0;
    while (!(m_upd && m_apply >= 0 && m_e > m_apply) && k < 60) begin
      step();
      k++;
    end
    chk("settle_reached", 32'(k < 60), 32'h1);
    chk("settle_busy", 32'(busy), 32'h1);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("midreset");
    exp_q.delete();
    cur_data = '0; cur_oe = '0; req_v = 0;
    @(negedge clk);
    rst_n = 1'b1;
    m_reset();
    repeat (SETL + 4) step();
    chk("codes_after_reset", 32'(c_pdrv), 32'h0);
    chk("no_pending_update", 32'(busy), 32'h0);

    // Keeper behaviour on ch2 (pulls unconfigured after reset)
    cur_oe[2] = 1; cur_data[2] = 1;
    step(); step();
    cur_oe[2] = 0;
    step();
`ifdef AIB_DRV_KEEPER_EN
    chk("keeper_hi", 32'(c_pu_n[2]), 32'h0);
`else
    chk("no_keeper_hi", 32'(c_pu_n[2]), 32'h1);
`endif
    cur_oe[2] = 1; cur_data[2] = 0;
    repeat (5) step();
    cur_oe[2] = 0;
    step();
`ifdef AIB_DRV_KEEPER_EN
    chk("keeper_lo", 32'(c_pd[2]), 32'h1);
`else
    chk("no_keeper_lo", 32'(c_pd[2]), 32'h0);
`endif

    // Randomized traffic with occasional config requests
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) cur_data = NCH'($urandom);
      if ($urandom_range(0, 7) == 0) cur_oe = NCH'($urandom);
      if (!req_v && $urandom_range(0, 40) == 0) begin
        req_v = 1; req_mask = NCH'($urandom); req_pc = DRV_W'($urandom);
        req_nc = DRV_W'($urandom); req_pu = 1'($urandom); req_pd = 1'($urandom);
      end
      step();
    end
    req_v = 0;
    repeat (20) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
